// File: rtl/cmp_scheduler.sv
// cmp_scheduler: round-robin sharing of one 4-bit magnitude comparator among four requesters
// Ports: clk, rst (sync, active-high); req[3:0], a_in/b_in[15:0] (4-bit slice per requester);
//   cmp_a/cmp_b drive the comparator, cmp_g/cmp_e are its g3/e3 outputs;
//   grant (one-hot owner), done pulse with done_id/gt/eq, busy.
// Option: define CMP_SCHED_RECHECK_EN to require two matching consecutive samples before answering.
module cmp_scheduler #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic [3:0]  cmp_a,
  output logic [3:0]  cmp_b,
  input  logic        cmp_g,
  input  logic        cmp_e,
  output logic [3:0]  grant,
  output logic        done,
  output logic [1:0]  done_id,
  output logic        gt,
  output logic        eq,
  output logic        busy
);
`ifdef CMP_SCHED_RECHECK_EN
  typedef enum logic [1:0] {IDLE, SETTLE, DONE, RECHECK} state_t;
  logic g_s, e_s;
`else
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
`endif
  state_t state, state_n;
  logic [1:0] ptr, own, win;
  logic [3:0] cnt, avail;
  logic win_ok, load, settled, cap;
  // the owner being answered in DONE is masked so a held req is not re-served back to back
  always_comb begin
    avail = req & ~(state == DONE ? grant : 4'b0);
    win_ok = |avail;
    win = ptr;
    for (int i = 3; i >= 0; i--)
      if (avail[ptr + 2'(i)]) win = ptr + 2'(i);
  end
  assign load = (state == IDLE || state == DONE) && win_ok;
  assign settled = state == SETTLE && cnt == 4'(SETTLE_CYCLES - 1);
`ifdef CMP_SCHED_RECHECK_EN
  assign cap = state == RECHECK && cmp_g == g_s && cmp_e == e_s;
`else
  assign cap = settled;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = win_ok ? SETTLE : IDLE;
`ifdef CMP_SCHED_RECHECK_EN
      SETTLE:  state_n = settled ? RECHECK : SETTLE;
      RECHECK: state_n = cap ? DONE : SETTLE;
`else
      SETTLE:  state_n = settled ? DONE : SETTLE;
`endif
      DONE:    state_n = win_ok ? SETTLE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      own <= '0;
      grant <= '0;
      cmp_a <= '0;
      cmp_b <= '0;
      cnt <= '0;
      done_id <= '0;
      gt <= 1'b0;
      eq <= 1'b0;
    end else begin
      state <= state_n;
      // counter restarts on every grant and on a failed recheck
      cnt <= (load || state != SETTLE) ? 4'd0 : cnt + 4'd1;
      if (load) begin
        grant <= 4'b1 << win;
        cmp_a <= a_in[{win, 2'b00} +: 4];
        cmp_b <= b_in[{win, 2'b00} +: 4];
        own <= win;
        ptr <= win + 2'd1;
      end else if (state == DONE) begin
        grant <= '0;
      end
      if (cap) begin
        gt <= cmp_g;
        eq <= cmp_e;
        done_id <= own;
      end
    end
  end
`ifdef CMP_SCHED_RECHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      g_s <= 1'b0;
      e_s <= 1'b0;
    end else if (settled) begin
      g_s <= cmp_g;
      e_s <= cmp_e;
    end
  end
`endif
  assign done = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_cmp_scheduler.sv
// tb_cmp_scheduler: directed self-checking bench for cmp_scheduler with a behavioural comparator
module tb_cmp_scheduler;
`ifdef CMP_SCHED_RECHECK_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0;
  logic [15:0] a_in = '0, b_in = '0;
  logic [3:0] cmp_a, cmp_b, grant;
  logic cmp_g, cmp_e, done, gt, eq, busy;
  logic [1:0] done_id;
  logic flip = 1'b0, flip_en = 1'b0;
  int tests = 0, fails = 0;
  cmp_scheduler #(.SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_g(cmp_g), .cmp_e(cmp_e),
    .grant(grant), .done(done), .done_id(done_id), .gt(gt), .eq(eq), .busy(busy)
  );
  always #5 clk = ~clk;
  assign cmp_g = (cmp_a > cmp_b) ^ flip;
  assign cmp_e = cmp_a == cmp_b;
  always @(posedge clk) flip <= flip_en ? ~flip : 1'b0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_done(input int lat);
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("latency", n, lat);
  endtask
  task automatic run_one(input int k, input logic [3:0] a, input logic [3:0] b, input logic eg, input logic ee);
    a_in[4*k +: 4] = a;
    b_in[4*k +: 4] = b;
    req = 4'b1 << k;
    tick();
    chk("grant", grant, 4'b1 << k);
    chk("cmp_a", cmp_a, a);
    chk("cmp_b", cmp_b, b);
    chk("busy", busy, 1);
    wait_done(LAT);
    chk("gt", gt, eg);
    chk("eq", eq, ee);
    chk("done_id", done_id, k);
    req = '0;
    tick();
    chk("done_pulse", done, 0);
    chk("idle_grant", grant, 0);
    chk("idle_busy", busy, 0);
  endtask
  task automatic check_reset();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmp_a", cmp_a, 0);
    chk("rst_cmp_b", cmp_b, 0);
    chk("rst_gt", gt, 0);
    chk("rst_eq", eq, 0);
    chk("rst_done_id", done_id, 0);
  endtask
  logic [3:0] va [4] = '{4'h1, 4'h9, 4'h4, 4'h7};
  logic [3:0] vb [4] = '{4'h2, 4'h3, 4'h4, 4'h8};
  logic eg [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic ee [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  initial begin
    tick();
    tick();
    check_reset();
    rst = 1'b0;
    run_one(0, 4'h5, 4'h5, 1'b0, 1'b1);
    run_one(0, 4'hA, 4'h3, 1'b1, 1'b0);
    run_one(0, 4'h2, 4'hB, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_in[4*k +: 4] = va[k];
      b_in[4*k +: 4] = vb[k];
    end
    req = 4'b1111;
    tick();
    chk("rr_first_grant", grant, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      wait_done(LAT);
      chk("rr_done_id", done_id, k);
      chk("rr_gt", gt, eg[k]);
      chk("rr_eq", eq, ee[k]);
      req[k] = 1'b0;
      tick();
      chk("rr_next_grant", grant, k < 3 ? 4'b1 << (k + 1) : 4'b0);
      chk("rr_busy", busy, k < 3);
    end
    a_in[11:8] = 4'hC;
    b_in[11:8] = 4'h6;
    req = 4'b0100;
    tick();
    chk("drop_grant", grant, 4'b0100);
    tick();
    a_in[11:8] = 4'h1;
    req = '0;
    wait_done(LAT - 1);
    chk("drop_gt", gt, 1);
    chk("drop_eq", eq, 0);
    chk("drop_done_id", done_id, 2);
    tick();
    chk("drop_idle", busy, 0);
    a_in[7:4] = 4'h3;
    b_in[7:4] = 4'h3;
    req = 4'b0010;
    tick();
    chk("abort_grant", grant, 4'b0010);
    tick();
    rst = 1'b1;
    tick();
    check_reset();
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    run_one(2, 4'h0, 4'hF, 1'b0, 1'b0);
`ifdef CMP_SCHED_RECHECK_EN
    begin
      int seen = 0;
      a_in[3:0] = 4'h9;
      b_in[3:0] = 4'h2;
      req = 4'b0001;
      flip_en = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
        tick();
        seen += done;
      end
      chk("recheck_no_done", seen, 0);
      flip_en = 1'b0;
      tick();
      wait_done(LAT + 1);
      chk("recheck_done", done, 1);
      chk("recheck_gt", gt, 1);
      chk("recheck_eq", eq, 0);
      req = '0;
      tick();
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
